// File: rtl/adc_rx_pkg.sv
// Shared types and constants for the serial ADC receiver.
// It covers the FSM state encoding, the frame geometry and the default timing parameters.
package adc_rx_pkg;

    localparam int FRAME_BITS           = 16;
    localparam int SAMPLE_BITS          = 12;
    localparam int LEAD_BITS            = FRAME_BITS - SAMPLE_BITS;
    localparam int DEFAULT_HALF_DIV     = 25;
    localparam int DEFAULT_QUIET_HALVES = 2;

    typedef enum logic [1:0] {
        IDLE,
        QUIET,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/adc_serial_rx_if.sv
// Bus between the ADC receiver (master) and its ADC/consumer side (slave).
// Defining ADC_RX_FRAME_CHECK_EN adds the frame_err signal.
interface adc_serial_rx_if;
    import adc_rx_pkg::*;

    logic                   enable;
    logic                   sdata;
    logic                   sclk;
    logic                   cs;
    logic [SAMPLE_BITS-1:0] sample;
    logic                   data_ready;
    logic [FRAME_BITS-1:0]  shift_dbg;

`ifdef ADC_RX_FRAME_CHECK_EN
    logic                   frame_err;

    modport master (input enable, sdata,
                    output sclk, cs, sample, data_ready, shift_dbg, frame_err);
    modport slave  (output enable, sdata,
                    input sclk, cs, sample, data_ready, shift_dbg, frame_err);
`else
    modport master (input enable, sdata,
                    output sclk, cs, sample, data_ready, shift_dbg);
    modport slave  (output enable, sdata,
                    input sclk, cs, sample, data_ready, shift_dbg);
`endif

endinterface

// File: rtl/adc_rx_tickgen.sv
// Half-period counter: counts 0..HALF_DIV-1 and ticks on the terminal count.
// While clear is high, the count is held at zero and no tick is produced.
module adc_rx_tickgen
    import adc_rx_pkg::*;
#(
    parameter int HALF_DIV = DEFAULT_HALF_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(HALF_DIV - 1);

    logic [7:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 8'd1;
        end
    end

    assign tick = !clear && (count == LAST);

endmodule

// File: rtl/adc_serial_rx.sv
// Serial ADC receiver: it generates cs and sclk, shifts in 16-bit frames and presents sample with a one-clk data_ready.
// Defining ADC_RX_FRAME_CHECK_EN adds frame_err, which flags non-zero leading frame bits.
module adc_serial_rx
    import adc_rx_pkg::*;
#(
    parameter int HALF_DIV     = DEFAULT_HALF_DIV,
    parameter int QUIET_HALVES = DEFAULT_QUIET_HALVES
) (
    input  logic           clk,
    input  logic           reset,
    adc_serial_rx_if.master bus
);

    localparam int              KW     = $clog2(2 * FRAME_BITS + 1);
    localparam logic [KW-1:0]   K_LAST = KW'(2 * FRAME_BITS - 1);
    localparam logic [3:0]      Q_LAST = 4'(QUIET_HALVES - 1);

    state_t                state;
    logic [KW-1:0]         k;
    logic [3:0]            halves;
    logic [FRAME_BITS-1:0] shift;
    logic                  tick;
    logic                  tick_clear;

    // Every state exit from QUIET or SHIFT coincides with the terminal count, so
    // holding the counter clear outside those states restarts it on each entry.
    assign tick_clear = (state != QUIET) && (state != SHIFT);

    adc_rx_tickgen #(
        .HALF_DIV (HALF_DIV)
    ) u_tickgen (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear),
        .tick  (tick)
    );

    assign bus.shift_dbg = shift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            k              <= '0;
            halves         <= '0;
            shift          <= '0;
            bus.cs         <= 1'b1;
            bus.sclk       <= 1'b1;
            bus.sample     <= '0;
            bus.data_ready <= 1'b0;
`ifdef ADC_RX_FRAME_CHECK_EN
            bus.frame_err  <= 1'b0;
`endif
        end else begin
            bus.data_ready <= 1'b0;
            case (state)
                IDLE: begin
                    halves <= '0;
                    if (bus.enable) begin
                        state <= QUIET;
                    end
                end
                QUIET: begin
                    if (tick) begin
                        if (halves == Q_LAST) begin
                            halves <= '0;
                            if (bus.enable) begin
                                state  <= SHIFT;
                                bus.cs <= 1'b0;
                                k      <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            halves <= halves + 4'd1;
                        end
                    end
                end
                // k counts completed half-periods: odd ticks lower sclk, even ticks raise it and capture sdata.
                SHIFT: begin
                    if (tick) begin
                        k <= k + 1'b1;
                        if (!k[0]) begin
                            bus.sclk <= 1'b0;
                        end else begin
                            bus.sclk <= 1'b1;
                            shift    <= {shift[FRAME_BITS-2:0], bus.sdata};
                            if (k == K_LAST) begin
                                state  <= DONE;
                                bus.cs <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    bus.sample     <= shift[SAMPLE_BITS-1:0];
                    bus.data_ready <= 1'b1;
`ifdef ADC_RX_FRAME_CHECK_EN
                    bus.frame_err  <= (shift[FRAME_BITS-1 -: LEAD_BITS] != '0);
`endif
                    halves         <= '0;
                    state          <= QUIET;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_serial_rx.sv
// Self-checking bench for adc_serial_rx: it uses an ADC word model and a monitor, and checks against frame-level timing rules.
// Defining ADC_RX_FRAME_CHECK_EN also checks frame_err.
module tb_adc_serial_rx;

    localparam int H       = 4;
    localparam int Q       = 3;
    localparam int CS_LOW  = 32 * H;
    localparam int PERIOD  = (32 + Q) * H + 1;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   cyc;

    adc_serial_rx_if bus ();

    adc_serial_rx #(
        .HALF_DIV     (H),
        .QUIET_HALVES (Q)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // ADC model: a cs fall loads the next word, and each sclk fall presents the next bit, MSB first.
    logic [15:0] frame_q[$];
    logic [15:0] sent_q[$];
    logic [15:0] cur_word;
    int          bit_idx;

    always @(negedge bus.cs or negedge bus.sclk) begin
        if (bus.sclk === 1'b1) begin
            if (frame_q.size() > 0) cur_word = frame_q.pop_front();
            else                    cur_word = 16'($urandom);
            sent_q.push_back(cur_word);
            bit_idx = 15;
        end else if (bus.cs === 1'b0 && bit_idx >= 0) begin
            bus.sdata = cur_word[bit_idx];
            bit_idx--;
        end
    end

    // Monitor: records sclk/cs edges and data_ready events once per clk, away from the active edge.
    int          sclk_rises = 0;
    int          sclk_edges = 0;
    int          last_rise  = 0;
    int          cs_fall    = 0;
    logic        prev_sclk  = 1'b1;
    logic        prev_cs    = 1'b1;
    int          cs_len[$];
    int          dr_cyc[$];
    int          dr_gap[$];
    logic [11:0] dr_val[$];
    logic [15:0] dr_dbg[$];
`ifdef ADC_RX_FRAME_CHECK_EN
    logic        dr_err[$];
`endif

    always @(negedge clk) begin
        if (prev_sclk !== bus.sclk) sclk_edges++;
        if (prev_sclk === 1'b0 && bus.sclk === 1'b1) begin
            sclk_rises++;
            last_rise = cyc;
        end
        if (prev_cs === 1'b1 && bus.cs === 1'b0) cs_fall = cyc;
        if (prev_cs === 1'b0 && bus.cs === 1'b1) cs_len.push_back(cyc - cs_fall);
        if (bus.data_ready === 1'b1) begin
            dr_cyc.push_back(cyc);
            dr_gap.push_back(cyc - last_rise);
            dr_val.push_back(bus.sample);
            dr_dbg.push_back(bus.shift_dbg);
`ifdef ADC_RX_FRAME_CHECK_EN
            dr_err.push_back(bus.frame_err);
`endif
        end
        prev_sclk = bus.sclk;
        prev_cs   = bus.cs;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic reportTimeout(input string tag);
        checks++;
        failures++;
        $error("FAIL timeout_%s observed=expired expected=event", tag);
    endtask

    task automatic applyStimulus(input logic en, input int cycles);
        bus.enable = en;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic waitPulses(input int n, input int limit);
        int t = 0;
        while (dr_val.size() < n && t < limit) begin
            @(negedge clk);
            t++;
        end
        if (dr_val.size() < n) reportTimeout("pulses");
    endtask

    task automatic waitCs(input logic level, input int limit);
        int t = 0;
        while (bus.cs !== level && t < limit) begin
            @(negedge clk);
            t++;
        end
        if (bus.cs !== level) reportTimeout("cs");
    endtask

    task automatic waitRises(input int n, input int limit);
        int t = 0;
        while (sclk_rises < n && t < limit) begin
            @(negedge clk);
            t++;
        end
        if (sclk_rises < n) reportTimeout("rises");
    endtask

    initial begin
        int n0;
        int e0;
        int l0;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        reset    = 1'b1;
        bus.enable = 1'b0;

        // Reset and idle.
        repeat (5) @(negedge clk);
        checkOutput("rst_cs", bus.cs, 1'b1);
        checkOutput("rst_sclk", bus.sclk, 1'b1);
        checkOutput("rst_sample", bus.sample, 12'h000);
        checkOutput("rst_ready", bus.data_ready, 1'b0);
        checkOutput("rst_dbg", bus.shift_dbg, 16'h0000);
        reset = 1'b0;
        applyStimulus(1'b0, 1000);
        checkOutput("idle_pulses", dr_val.size(), 0);
        checkOutput("idle_sclk_edges", sclk_edges, 0);
        checkOutput("idle_cs", bus.cs, 1'b1);

        // Single frame followed by back-to-back frames.
        frame_q.push_back(16'h0ABC);
        frame_q.push_back(16'h0000);
        frame_q.push_back(16'h0FFF);
        frame_q.push_back(16'hFFFF);
        for (int i = 0; i < 16; i++) frame_q.push_back(16'($urandom));
        bus.enable = 1'b1;
        waitPulses(20, 25 * PERIOD);
        checkOutput("first_sample", dr_val[0], 12'hABC);
        checkOutput("first_dbg", dr_dbg[0], 16'h0ABC);
        for (int i = 0; i < 20; i++) begin
            checkOutput($sformatf("sample_%0d", i), dr_val[i], sent_q[i][11:0]);
            checkOutput($sformatf("dbg_%0d", i), dr_dbg[i], sent_q[i]);
            checkOutput($sformatf("cs_low_%0d", i), cs_len[i], CS_LOW);
            checkOutput($sformatf("rise_gap_%0d", i), dr_gap[i], 1);
            if (i > 0)
                checkOutput($sformatf("spacing_%0d", i), dr_cyc[i] - dr_cyc[i-1], PERIOD);
        end

        // Enable dropped mid-frame: that frame completes, then the receiver goes quiet.
        waitCs(1'b1, 2 * PERIOD);
        waitCs(1'b0, 2 * PERIOD);
        waitRises(sclk_rises + 5, 2 * PERIOD);
        n0 = dr_val.size();
        applyStimulus(1'b0, 3 * PERIOD);
        checkOutput("drop_pulses", dr_val.size(), n0 + 1);
        checkOutput("drop_sample", dr_val[n0], sent_q[sent_q.size()-1][11:0]);
        e0 = sclk_edges;
        l0 = cs_len.size();
        applyStimulus(1'b0, 2 * PERIOD);
        checkOutput("drop_sclk_edges", sclk_edges, e0);
        checkOutput("drop_cs_frames", cs_len.size(), l0);
        checkOutput("drop_cs", bus.cs, 1'b1);
        checkOutput("drop_sclk", bus.sclk, 1'b1);
        checkOutput("drop_no_extra", dr_val.size(), n0 + 1);

        // Reset mid-frame: outputs return at once, and the partial frame is discarded.
        frame_q.delete();
        bus.enable = 1'b1;
        waitCs(1'b0, 2 * PERIOD);
        waitRises(sclk_rises + 10, 2 * PERIOD);
        n0 = dr_val.size();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst_cs", bus.cs, 1'b1);
        checkOutput("midrst_sclk", bus.sclk, 1'b1);
        checkOutput("midrst_ready", bus.data_ready, 1'b0);
        checkOutput("midrst_dbg", bus.shift_dbg, 16'h0000);
        frame_q.push_back(16'h0123);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("midrst_no_pulse", dr_val.size(), n0);
        waitPulses(n0 + 1, 2 * PERIOD);
        checkOutput("post_rst_sample", dr_val[n0], 12'h123);

`ifdef ADC_RX_FRAME_CHECK_EN
        // Leading-bit check on frames with and without non-zero upper bits.
        applyStimulus(1'b0, 3 * PERIOD);
        frame_q.delete();
        n0 = dr_val.size();
        frame_q.push_back(16'hF555);
        frame_q.push_back(16'h0555);
        bus.enable = 1'b1;
        waitPulses(n0 + 2, 4 * PERIOD);
        bus.enable = 1'b0;
        checkOutput("ferr_sample_a", dr_val[n0], 12'h555);
        checkOutput("ferr_flag_a", dr_err[n0], 1'b1);
        checkOutput("ferr_sample_b", dr_val[n0+1], 12'h555);
        checkOutput("ferr_flag_b", dr_err[n0+1], 1'b0);
`endif

        $display("[TB] TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
